// File: rtl/pedal_misapply_detector_pkg.sv
// Shared types and constants for the pedal misapplication detector.
// Holds the FSM encoding, the default thresholds and the counter-width helper.
package pedal_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_SUSPECT = 2'd2,
        ST_ALARM   = 2'd3
    } state_e;

    localparam int DEF_THRESH_LOW  = 25;
    localparam int DEF_THRESH_HIGH = 75;
    localparam int DEF_THRESH_PEAK = 99;

    // Bits needed to hold values 0..value-1; callers pass N+1 to hold 0..N.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pedal_misapply_detector_if.sv
// Sample/alarm bundle between the pedal front end and the detector.
// The front end drives the master side; the detector sits on the slave side.
interface pedal_misapply_detector_if #(
    parameter int SAMPLE_W = 8,
    parameter int RATE_W   = 16
);
    logic                tick;
    logic [SAMPLE_W-1:0] pedal_in;
    logic                brake_in;
    logic                clear;
    logic                pedal_flag;
    logic                flag_pulse;
    logic [RATE_W-1:0]   rate_inst;
    logic [RATE_W-1:0]   rate_avg;
    logic                window_full;
    logic [1:0]          state;

    modport master (
        output tick, pedal_in, brake_in, clear,
        input  pedal_flag, flag_pulse, rate_inst, rate_avg, window_full, state
    );

    modport slave (
        input  tick, pedal_in, brake_in, clear,
        output pedal_flag, flag_pulse, rate_inst, rate_avg, window_full, state
    );
endinterface

// File: rtl/pedal_misapply_detector_rate_window.sv
// Power-of-two tap shift register with a rolling sum of the rate samples.
// The next sum is exposed combinationally so the caller can evaluate on the same tick.
module rate_window #(
    parameter int RATE_W     = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shift_en,
    input  logic                         clr,
    input  logic [RATE_W-1:0]            rate_next,
    output logic [RATE_W+DEPTH_LOG2-1:0] sum_next,
    output logic [RATE_W-1:0]            avg
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = RATE_W + DEPTH_LOG2;

    logic [RATE_W-1:0] taps_r [DEPTH];
    logic [SUM_W-1:0]  sum_r;
    logic [RATE_W-1:0] avg_r;

    // Modular subtract-then-add is exact because the true sum always fits SUM_W.
    always_comb begin
        sum_next = sum_r - SUM_W'(taps_r[DEPTH-1]) + SUM_W'(rate_next);
    end

    // Tap shift, rolling sum and registered average.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_r[i] <= {RATE_W{1'b0}};
            end
            sum_r <= {SUM_W{1'b0}};
            avg_r <= {RATE_W{1'b0}};
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_r[i] <= {RATE_W{1'b0}};
            end
            sum_r <= {SUM_W{1'b0}};
            avg_r <= {RATE_W{1'b0}};
        end else if (shift_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                taps_r[i] <= taps_r[i-1];
            end
            taps_r[0] <= rate_next;
            sum_r     <= sum_next;
            avg_r     <= RATE_W'(sum_next >> DEPTH_LOG2);
        end
    end

    assign avg = avg_r;

endmodule

// File: rtl/pedal_misapply_detector.sv
// Pedal misapplication detector: pedal rate, windowed average, confirm/hold alarm FSM.
// All outputs are registered and move only on tick or clear.
module pedal_misapply_detector
    import pedal_pkg::*;
#(
    parameter int SAMPLE_W    = 8,
    parameter int SCALE       = 10,
    parameter int RATE_W      = 16,
    parameter int DEPTH_LOG2  = 3,
    parameter int THRESH_LOW  = DEF_THRESH_LOW,
    parameter int THRESH_HIGH = DEF_THRESH_HIGH,
    parameter int THRESH_PEAK = DEF_THRESH_PEAK,
    parameter int CONFIRM_N   = 2,
    parameter int HOLD_TICKS  = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    pedal_misapply_detector_if.slave        bus
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int SUM_W  = RATE_W + DEPTH_LOG2;
    localparam int PROD_W = SAMPLE_W + 32;
    localparam int FILL_W = clog2(DEPTH + 1);
    localparam int HIT_W  = clog2(CONFIRM_N + 1);
    localparam int HOLD_W = clog2(HOLD_TICKS + 1);

    logic [SAMPLE_W-1:0]  prev_r;
    logic                 baseline_pending_r;
    state_e               state_r;
    logic [FILL_W-1:0]    fill_cnt_r;
    logic [HIT_W-1:0]     hit_cnt_r;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic [RATE_W-1:0]    rate_inst_r;
    logic                 window_full_r;
    logic                 pedal_flag_r;
    logic                 flag_pulse_r;

    logic signed [SAMPLE_W:0] delta_s;
    logic [PROD_W-1:0]        product_s;
    logic [RATE_W-1:0]        rate_next_s;
    logic [SUM_W-1:0]         sum_next_s;
    logic [RATE_W-1:0]        avg_next_s;
    logic [RATE_W-1:0]        avg_s;
    logic                     hit_s;
    logic                     rate_tick_s;

    // Positive-only rate, saturated, and the hit decision on the incoming sample.
    always_comb begin
        delta_s = $signed({1'b0, bus.pedal_in}) - $signed({1'b0, prev_r});
        if (delta_s > $signed({(SAMPLE_W + 1){1'b0}})) begin
            product_s = PROD_W'(delta_s[SAMPLE_W-1:0]) * PROD_W'(SCALE);
        end else begin
            product_s = {PROD_W{1'b0}};
        end
        if (product_s > PROD_W'({RATE_W{1'b1}})) begin
            rate_next_s = {RATE_W{1'b1}};
        end else begin
            rate_next_s = RATE_W'(product_s);
        end
        avg_next_s  = RATE_W'(sum_next_s >> DEPTH_LOG2);
        hit_s       = ((rate_next_s >= RATE_W'(THRESH_LOW)) && (avg_next_s >= RATE_W'(THRESH_HIGH)))
                      || (rate_next_s >= RATE_W'(THRESH_PEAK));
        rate_tick_s = bus.tick && !bus.clear && !baseline_pending_r;
    end

    rate_window #(
        .RATE_W     (RATE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rate_window (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (rate_tick_s),
        .clr       (bus.clear),
        .rate_next (rate_next_s),
        .sum_next  (sum_next_s),
        .avg       (avg_s)
    );

    // Baseline capture, confirm/hold FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r             <= {SAMPLE_W{1'b0}};
            baseline_pending_r <= 1'b1;
            state_r            <= ST_FILL;
            fill_cnt_r         <= {FILL_W{1'b0}};
            hit_cnt_r          <= {HIT_W{1'b0}};
            hold_cnt_r         <= {HOLD_W{1'b0}};
            rate_inst_r        <= {RATE_W{1'b0}};
            window_full_r      <= 1'b0;
            pedal_flag_r       <= 1'b0;
            flag_pulse_r       <= 1'b0;
        end else if (bus.clear) begin
            prev_r             <= {SAMPLE_W{1'b0}};
            baseline_pending_r <= 1'b1;
            state_r            <= ST_FILL;
            fill_cnt_r         <= {FILL_W{1'b0}};
            hit_cnt_r          <= {HIT_W{1'b0}};
            hold_cnt_r         <= {HOLD_W{1'b0}};
            rate_inst_r        <= {RATE_W{1'b0}};
            window_full_r      <= 1'b0;
            pedal_flag_r       <= 1'b0;
            flag_pulse_r       <= 1'b0;
        end else begin
            flag_pulse_r <= 1'b0;
            if (bus.tick) begin
                prev_r <= bus.pedal_in;
                if (baseline_pending_r) begin
                    baseline_pending_r <= 1'b0;
                end else begin
                    rate_inst_r <= rate_next_s;
                    case (state_r)
                        ST_FILL: begin
                            fill_cnt_r <= fill_cnt_r + FILL_W'(1);
                            if (fill_cnt_r + FILL_W'(1) == FILL_W'(DEPTH)) begin
                                window_full_r <= 1'b1;
                                state_r       <= ST_ARMED;
                            end
                        end
                        ST_ARMED: begin
                            if (hit_s && (CONFIRM_N <= 1)) begin
                                state_r      <= ST_ALARM;
                                hold_cnt_r   <= HOLD_W'(HOLD_TICKS);
                                pedal_flag_r <= 1'b1;
                                flag_pulse_r <= 1'b1;
                            end else if (hit_s) begin
                                state_r   <= ST_SUSPECT;
                                hit_cnt_r <= HIT_W'(1);
                            end
                        end
                        ST_SUSPECT: begin
                            if (hit_s && (hit_cnt_r + HIT_W'(1) >= HIT_W'(CONFIRM_N))) begin
                                state_r      <= ST_ALARM;
                                hit_cnt_r    <= {HIT_W{1'b0}};
                                hold_cnt_r   <= HOLD_W'(HOLD_TICKS);
                                pedal_flag_r <= 1'b1;
                                flag_pulse_r <= 1'b1;
                            end else if (hit_s) begin
                                hit_cnt_r <= hit_cnt_r + HIT_W'(1);
                            end else begin
                                state_r   <= ST_ARMED;
                                hit_cnt_r <= {HIT_W{1'b0}};
                            end
                        end
                        ST_ALARM: begin
                            if (hit_s) begin
                                hold_cnt_r <= HOLD_W'(HOLD_TICKS);
                            end else if (bus.brake_in || (hold_cnt_r <= HOLD_W'(1))) begin
                                state_r      <= ST_ARMED;
                                hold_cnt_r   <= {HOLD_W{1'b0}};
                                pedal_flag_r <= 1'b0;
                            end else begin
                                hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
                            end
                        end
                        default: begin
                            state_r      <= ST_FILL;
                            pedal_flag_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.pedal_flag  = pedal_flag_r;
    assign bus.flag_pulse  = flag_pulse_r;
    assign bus.rate_inst   = rate_inst_r;
    assign bus.rate_avg    = avg_s;
    assign bus.window_full = window_full_r;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_pedal_misapply_detector.sv
// Directed-vector bench for pedal_misapply_detector with hand-computed expectations.
module tb_pedal_misapply_detector;

    logic clk;
    logic rst;
    int   check_cnt;
    int   error_cnt;

    pedal_misapply_detector_if #(.SAMPLE_W(8), .RATE_W(16)) bus_if ();

    pedal_misapply_detector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int observed, input int expected);
        check_cnt++;
        if (observed != expected) begin
            error_cnt++;
            $display("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one tick for one clock; returns at the following negedge with outputs settled.
    task automatic drive_tick(input int pedal, input logic brake);
        @(negedge clk);
        bus_if.tick     = 1'b1;
        bus_if.pedal_in = 8'(pedal);
        bus_if.brake_in = brake;
        @(negedge clk);
        bus_if.tick     = 1'b0;
        bus_if.brake_in = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus_if.clear = 1'b1;
        @(negedge clk);
        bus_if.clear = 1'b0;
    endtask

    initial begin
        clk             = 1'b0;
        rst             = 1'b1;
        check_cnt       = 0;
        error_cnt       = 0;
        bus_if.tick     = 1'b0;
        bus_if.pedal_in = 8'd0;
        bus_if.brake_in = 1'b0;
        bus_if.clear    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_value("rst_flag",  int'(bus_if.pedal_flag), 0);
        check_value("rst_pulse", int'(bus_if.flag_pulse), 0);
        check_value("rst_inst",  int'(bus_if.rate_inst), 0);
        check_value("rst_avg",   int'(bus_if.rate_avg), 0);
        check_value("rst_full",  int'(bus_if.window_full), 0);
        check_value("rst_state", int'(bus_if.state), 0);
        rst = 1'b0;

        // Fill without alarm: +3 per tick gives rate 30
        drive_tick(0, 1'b0);
        check_value("base_inst", int'(bus_if.rate_inst), 0);
        for (int k = 1; k <= 10; k++) begin
            drive_tick(3 * k, 1'b0);
            if (k == 7) begin
                check_value("fill7_avg",  int'(bus_if.rate_avg), 26);
                check_value("fill7_full", int'(bus_if.window_full), 0);
                check_value("fill7_state", int'(bus_if.state), 0);
            end
            if (k == 8) begin
                check_value("fill8_avg",   int'(bus_if.rate_avg), 30);
                check_value("fill8_full",  int'(bus_if.window_full), 1);
                check_value("fill8_state", int'(bus_if.state), 1);
            end
        end
        check_value("fill_inst",  int'(bus_if.rate_inst), 30);
        check_value("fill_flag",  int'(bus_if.pedal_flag), 0);
        check_value("fill_state", int'(bus_if.state), 1);

        // Peak hits: two +10 steps reach ALARM
        drive_tick(40, 1'b0);
        check_value("pk1_inst",  int'(bus_if.rate_inst), 100);
        check_value("pk1_avg",   int'(bus_if.rate_avg), 38);
        check_value("pk1_state", int'(bus_if.state), 2);
        drive_tick(50, 1'b0);
        check_value("pk2_state", int'(bus_if.state), 3);
        check_value("pk2_flag",  int'(bus_if.pedal_flag), 1);
        check_value("pk2_pulse", int'(bus_if.flag_pulse), 1);
        @(negedge clk);
        check_value("pk2_pulse_off", int'(bus_if.flag_pulse), 0);
        check_value("pk2_flag_hold", int'(bus_if.pedal_flag), 1);
        drive_tick(50, 1'b1);
        check_value("pk_brake_state", int'(bus_if.state), 1);
        drive_tick(60, 1'b0);
        check_value("single_state", int'(bus_if.state), 2);
        drive_tick(60, 1'b0);
        check_value("single_back", int'(bus_if.state), 1);

        // Sustained +8 push then flat hold
        pulse_clear();
        check_value("clr_state", int'(bus_if.state), 0);
        drive_tick(0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            drive_tick(8 * k, 1'b0);
        end
        check_value("sus_fill_state", int'(bus_if.state), 1);
        drive_tick(72, 1'b0);
        check_value("sus9_state", int'(bus_if.state), 2);
        drive_tick(80, 1'b0);
        check_value("sus10_state", int'(bus_if.state), 3);
        check_value("sus10_pulse", int'(bus_if.flag_pulse), 1);
        for (int i = 1; i <= 20; i++) begin
            drive_tick(80, 1'b0);
            check_value($sformatf("hold_flag_%0d", i), int'(bus_if.pedal_flag), (i < 20) ? 1 : 0);
        end
        check_value("hold_end_state", int'(bus_if.state), 1);

        // Brake release and rate limits
        drive_tick(90, 1'b0);
        drive_tick(100, 1'b0);
        check_value("brk_alarm", int'(bus_if.state), 3);
        drive_tick(100, 1'b1);
        check_value("brk_state", int'(bus_if.state), 1);
        check_value("brk_flag",  int'(bus_if.pedal_flag), 0);
        drive_tick(50, 1'b0);
        check_value("dec_inst", int'(bus_if.rate_inst), 0);
        drive_tick(0, 1'b0);
        drive_tick(255, 1'b0);
        check_value("step_inst", int'(bus_if.rate_inst), 2550);

        // Clear together with tick while in ALARM
        drive_tick(200, 1'b0);
        drive_tick(220, 1'b0);
        drive_tick(240, 1'b0);
        check_value("pre_clr_state", int'(bus_if.state), 3);
        @(negedge clk);
        bus_if.clear    = 1'b1;
        bus_if.tick     = 1'b1;
        bus_if.pedal_in = 8'd250;
        @(negedge clk);
        bus_if.clear = 1'b0;
        bus_if.tick  = 1'b0;
        check_value("ct_flag",  int'(bus_if.pedal_flag), 0);
        check_value("ct_state", int'(bus_if.state), 0);
        check_value("ct_avg",   int'(bus_if.rate_avg), 0);
        check_value("ct_full",  int'(bus_if.window_full), 0);
        drive_tick(10, 1'b0);
        check_value("ct_base_inst", int'(bus_if.rate_inst), 0);
        drive_tick(20, 1'b0);
        check_value("ct_first_inst", int'(bus_if.rate_inst), 100);
        check_value("ct_first_avg",  int'(bus_if.rate_avg), 12);

        // Reach ALARM again, then assert reset asynchronously
        for (int k = 2; k <= 10; k++) begin
            drive_tick(20 * k, 1'b0);
        end
        check_value("rr_state", int'(bus_if.state), 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("ar_flag",  int'(bus_if.pedal_flag), 0);
        check_value("ar_state", int'(bus_if.state), 0);
        check_value("ar_inst",  int'(bus_if.rate_inst), 0);
        check_value("ar_avg",   int'(bus_if.rate_avg), 0);
        check_value("ar_full",  int'(bus_if.window_full), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
